// File: rtl/memory_bus_arbiter_pkg.sv
// Shared bus package for memory_bus_arbiter.
// Defines the bus packet layout, the packet type enum and a saturating
// counter helper used by the optional statistics counters
// (enabled by the MEMORY_BUS_STATS_EN macro in memory_bus_arbiter).
package memory_bus_arbiter_pkg;

  typedef logic [3:0]  BusID;
  typedef logic [15:0] memory_address_t;
  typedef logic [31:0] bus_packet_payload_t;

  typedef enum logic [1:0] {
    bus_read_data     = 2'd0,
    bus_write_data    = 2'd1,
    bus_read_response = 2'd2
  } bus_packet_type_t;

  // 'type' is a reserved word, so the packet type field is named ptype.
  typedef struct packed {
    bus_packet_type_t    ptype;
    BusID                source;
    memory_address_t     address;
    bus_packet_payload_t payload;
  } BusPacket;

  localparam int unsigned STAT_W = 32;

  // Increment that sticks at the all-ones value instead of wrapping.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] value);
    return (value == {STAT_W{1'b1}}) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/memory_bus_arbiter_fifo.sv
// bus_packet_fifo: synchronous FIFO of BusPacket entries.
// Ports:
//   clk, reset        clock, synchronous active-high reset (empties the FIFO)
//   push, push_data   write an entry (ignored when full)
//   pop               remove the head entry (ignored when empty)
//   full, empty       occupancy flags
//   head              head entry, read from registered storage (no bypass,
//                     so a pushed entry becomes visible one cycle later)
module bus_packet_fifo
  import memory_bus_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     push,
  input  BusPacket push_data,
  input  logic     pop,
  output logic     full,
  output logic     empty,
  output BusPacket head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  BusPacket      mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_ok_s, pop_ok_s;

  assign full      = (count_q == FULL_COUNT);
  assign empty     = (count_q == {(AW+1){1'b0}});
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;
  assign head      = mem_q[rd_ptr_q];

  // Next pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {(AW+1){1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are don't-care while the slot is unoccupied.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/memory_bus_arbiter.sv
// memory_bus_arbiter: connects NUM_CLIENTS requesters to one memory port.
// A round-robin arbiter feeds a request FIFO; a response FIFO returns
// responses to the client named in each packet's source field.
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   req_valid/req_data/req_ready  per-client request channel (ready one-hot)
//   mem_req_valid/data/ready      request FIFO head towards memory
//   mem_rsp_valid/data/ready      responses from memory into response FIFO
//   rsp_valid/rsp_data/rsp_ready  response head, data broadcast, valid one-hot
// Optional macro MEMORY_BUS_STATS_EN adds stat_grants, stat_req_stalls and
// stat_rsp_drops saturating 32-bit counters.
module memory_bus_arbiter
  import memory_bus_arbiter_pkg::*;
#(
  parameter int NUM_CLIENTS = 4,
  parameter int REQ_DEPTH   = 4,
  parameter int RSP_DEPTH   = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_CLIENTS-1:0] req_valid,
  input  BusPacket [NUM_CLIENTS-1:0] req_data,
  output logic [NUM_CLIENTS-1:0] req_ready,
  output logic                   mem_req_valid,
  output BusPacket               mem_req_data,
  input  logic                   mem_req_ready,
  input  logic                   mem_rsp_valid,
  input  BusPacket               mem_rsp_data,
  output logic                   mem_rsp_ready,
  output logic [NUM_CLIENTS-1:0] rsp_valid,
  output BusPacket               rsp_data,
  input  logic [NUM_CLIENTS-1:0] rsp_ready
`ifdef MEMORY_BUS_STATS_EN
  ,
  output logic [31:0]            stat_grants,
  output logic [31:0]            stat_req_stalls,
  output logic [31:0]            stat_rsp_drops
`endif
);

  localparam int PTR_W = $clog2(NUM_CLIENTS);
  localparam logic [4:0] NUM_CLIENTS_W = 5'(NUM_CLIENTS);

  logic [PTR_W-1:0]       ptr_q, ptr_d;
  logic [PTR_W-1:0]       gnt_idx_s;
  logic [NUM_CLIENTS-1:0] grant_s;
  logic                   gnt_any_s;
  logic                   req_full_s, req_empty_s;
  logic                   rsp_full_s, rsp_empty_s;
  logic                   rsp_pop_s, rsp_in_range_s;
  logic [PTR_W-1:0]       rsp_idx_s;
  BusPacket               rsp_head_s;

  // (base + off) mod NUM_CLIENTS for base, off < NUM_CLIENTS.
  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base,
                                                input int unsigned     off);
    int unsigned sum;
    sum = 32'(base) + off;
    sum = (sum >= 32'(NUM_CLIENTS)) ? sum - 32'(NUM_CLIENTS) : sum;
    return sum[PTR_W-1:0];
  endfunction

  // Round-robin search from the pointer; a full request FIFO blocks every grant
  // regardless of a same-cycle pop, so req_ready never depends on mem_req_ready.
  always_comb begin
    grant_s   = {NUM_CLIENTS{1'b0}};
    gnt_idx_s = {PTR_W{1'b0}};
    gnt_any_s = 1'b0;
    if (!req_full_s) begin
      for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
        if (!gnt_any_s && req_valid[wrap_add(ptr_q, i)]) begin
          gnt_any_s                    = 1'b1;
          gnt_idx_s                    = wrap_add(ptr_q, i);
          grant_s[wrap_add(ptr_q, i)] = 1'b1;
        end else begin
          gnt_any_s = gnt_any_s;
        end
      end
    end else begin
      gnt_any_s = 1'b0;
    end
    ptr_d = gnt_any_s ? wrap_add(gnt_idx_s, 32'd1) : ptr_q;
  end

  // Round-robin pointer register.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= {PTR_W{1'b0}};
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign req_ready = grant_s;

  bus_packet_fifo #(.DEPTH(REQ_DEPTH)) u_req_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (gnt_any_s),
    .push_data (req_data[gnt_idx_s]),
    .pop       (mem_req_valid && mem_req_ready),
    .full      (req_full_s),
    .empty     (req_empty_s),
    .head      (mem_req_data)
  );

  assign mem_req_valid = !req_empty_s;

  bus_packet_fifo #(.DEPTH(RSP_DEPTH)) u_rsp_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (mem_rsp_valid),
    .push_data (mem_rsp_data),
    .pop       (rsp_pop_s),
    .full      (rsp_full_s),
    .empty     (rsp_empty_s),
    .head      (rsp_head_s)
  );

  assign mem_rsp_ready  = !rsp_full_s;
  assign rsp_data       = rsp_head_s;
  assign rsp_in_range_s = ({1'b0, rsp_head_s.source} < NUM_CLIENTS_W);
  // Only meaningful when in range, where the truncation is exact.
  assign rsp_idx_s      = rsp_head_s.source[PTR_W-1:0];

  // Route the head to its client; out-of-range heads are popped silently.
  always_comb begin
    rsp_valid = {NUM_CLIENTS{1'b0}};
    rsp_pop_s = 1'b0;
    if (!rsp_empty_s) begin
      if (rsp_in_range_s) begin
        rsp_valid[rsp_idx_s] = 1'b1;
        rsp_pop_s            = rsp_ready[rsp_idx_s];
      end else begin
        rsp_pop_s = 1'b1;
      end
    end else begin
      rsp_pop_s = 1'b0;
    end
  end

`ifdef MEMORY_BUS_STATS_EN
  logic [31:0] stat_grants_q, stat_req_stalls_q, stat_rsp_drops_q;
  logic        rsp_drop_s;

  assign rsp_drop_s = !rsp_empty_s && !rsp_in_range_s;

  // Saturating event counters, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_grants_q     <= 32'd0;
      stat_req_stalls_q <= 32'd0;
      stat_rsp_drops_q  <= 32'd0;
    end else begin
      if (gnt_any_s) begin
        stat_grants_q <= sat_inc(stat_grants_q);
      end
      if (|req_valid && !gnt_any_s) begin
        stat_req_stalls_q <= sat_inc(stat_req_stalls_q);
      end
      if (rsp_drop_s) begin
        stat_rsp_drops_q <= sat_inc(stat_rsp_drops_q);
      end
    end
  end

  assign stat_grants     = stat_grants_q;
  assign stat_req_stalls = stat_req_stalls_q;
  assign stat_rsp_drops  = stat_rsp_drops_q;
`endif

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Self-checking bench for memory_bus_arbiter (NUM_CLIENTS=4, depths 4).
// A queue-based reference model predicts every output; directed scenarios
// also check against hand-derived constants.
module tb_memory_bus_arbiter;
  import memory_bus_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int RD = 4;
  localparam int SD = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [N-1:0]     req_valid;
  BusPacket [N-1:0] req_data;
  logic [N-1:0]     req_ready;
  logic             mem_req_valid;
  BusPacket         mem_req_data;
  logic             mem_req_ready;
  logic             mem_rsp_valid;
  BusPacket         mem_rsp_data;
  logic             mem_rsp_ready;
  logic [N-1:0]     rsp_valid;
  BusPacket         rsp_data;
  logic [N-1:0]     rsp_ready;
`ifdef MEMORY_BUS_STATS_EN
  logic [31:0]      stat_grants, stat_req_stalls, stat_rsp_drops;
`endif

  always #5 clk = ~clk;

  memory_bus_arbiter #(.NUM_CLIENTS(N), .REQ_DEPTH(RD), .RSP_DEPTH(SD)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .mem_req_valid(mem_req_valid), .mem_req_data(mem_req_data), .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_ready(mem_rsp_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready)
`ifdef MEMORY_BUS_STATS_EN
    , .stat_grants(stat_grants), .stat_req_stalls(stat_req_stalls), .stat_rsp_drops(stat_rsp_drops)
`endif
  );

  int tests = 0;
  int fails = 0;

  // Reference model state
  BusPacket mq[$];
  BusPacket rq[$];
  int       mptr = 0;
  longint   st_g = 0, st_s = 0, st_d = 0;

  // Model predictions for the current cycle
  logic [N-1:0] e_req_ready, e_rsp_valid;
  logic         e_mem_req_valid, e_mem_rsp_ready;
  BusPacket     e_mem_req_data, e_rsp_data;
  int           e_gnt;

  function automatic BusPacket mk(input int src, input int tag);
    BusPacket p;
    p.ptype   = bus_read_data;
    p.source  = BusID'(src);
    p.address = memory_address_t'(tag);
    p.payload = 32'(tag * 7 + 1);
    return p;
  endfunction

  function automatic bit bit_of(input logic [N-1:0] v, input int i);
    logic [N-1:0] s;
    s = v >> i;
    return s[0];
  endfunction

  task automatic model_expect();
    logic [N-1:0] one;
    one = 4'b0001;
    e_req_ready = '0;
    e_gnt = -1;
    if (mq.size() < RD) begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (mptr + k) % N;
        if (e_gnt < 0 && bit_of(req_valid, c)) begin
          e_gnt = c;
          e_req_ready = one << c;
        end
      end
    end
    e_mem_req_valid = (mq.size() > 0);
    e_mem_req_data  = (mq.size() > 0) ? mq[0] : '0;
    e_mem_rsp_ready = (rq.size() < SD);
    e_rsp_valid = '0;
    e_rsp_data  = '0;
    if (rq.size() > 0) begin
      e_rsp_data = rq[0];
      if (int'(rq[0].source) < N) e_rsp_valid = one << rq[0].source;
    end
  endtask

  // Capture this cycle's transfers, wait for the edge, then update the model.
  task automatic model_clock();
    bit       rst_v, mq_pop, rq_push, rq_pop, drop, stall;
    BusPacket mq_in, rq_in;
    int       g;
    rst_v   = reset;
    g       = e_gnt;
    mq_pop  = e_mem_req_valid && mem_req_ready;
    mq_in   = (g >= 0) ? req_data[g] : '0;
    rq_push = mem_rsp_valid && e_mem_rsp_ready;
    rq_in   = mem_rsp_data;
    rq_pop  = 0;
    drop    = 0;
    stall   = (req_valid != '0) && (g < 0);
    if (rq.size() > 0) begin
      if (int'(rq[0].source) >= N) begin
        rq_pop = 1;
        drop   = 1;
      end else if (bit_of(rsp_ready, int'(rq[0].source))) begin
        rq_pop = 1;
      end
    end
    @(posedge clk);
    if (rst_v) begin
      mq.delete();
      rq.delete();
      mptr = 0;
      st_g = 0; st_s = 0; st_d = 0;
    end else begin
      if (mq_pop) void'(mq.pop_front());
      if (g >= 0) begin
        mq.push_back(mq_in);
        mptr = (g + 1) % N;
        st_g++;
      end
      if (stall) st_s++;
      if (rq_pop) void'(rq.pop_front());
      if (rq_push) rq.push_back(rq_in);
      if (drop) st_d++;
    end
  endtask

  task automatic idle_inputs();
    req_valid = '0;
    for (int i = 0; i < N; i++) req_data[i] = '0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    rsp_ready     = '0;
  endtask

  task automatic do_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      idle_inputs();
      reset = (c < 2);
      #1;
      model_expect();
      model_clock();
    end
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      idle_inputs();
      reset = 1'b1;
      #1;
      model_expect();
      model_clock();
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    model_expect();
    tests++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
    tests++; if (mem_req_valid !== 1'b0) begin fails++; $display("FAIL reset_mem_req_valid got=%b exp=0", mem_req_valid); end
    tests++; if (mem_rsp_ready !== 1'b1) begin fails++; $display("FAIL reset_mem_rsp_ready got=%b exp=1", mem_rsp_ready); end
    tests++; if (rsp_valid !== 4'b0000) begin fails++; $display("FAIL reset_rsp_valid got=%b exp=0000", rsp_valid); end
`ifdef MEMORY_BUS_STATS_EN
    tests++;
    if ({stat_grants, stat_req_stalls, stat_rsp_drops} !== 96'd0) begin
      fails++; $display("FAIL reset_stats got=%0d/%0d/%0d exp=0/0/0", stat_grants, stat_req_stalls, stat_rsp_drops);
    end
`endif
    model_clock();
  endtask

  task automatic test_round_robin();
    logic [N-1:0] one, exp_rr;
    one = 4'b0001;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      req_valid = 4'b1111;
      for (int i = 0; i < N; i++) req_data[i] = mk(i, 16 * c + i);
      mem_req_ready = 1'b1;
      #1;
      model_expect();
      exp_rr = one << (c % N);
      tests++; if (req_ready !== exp_rr) begin fails++; $display("FAIL rr_grant cyc=%0d got=%b exp=%b", c, req_ready, exp_rr); end
      tests++; if (req_ready !== e_req_ready) begin fails++; $display("FAIL rr_model cyc=%0d got=%b exp=%b", c, req_ready, e_req_ready); end
      if (c > 0) begin
        tests++;
        if (mem_req_valid !== 1'b1 || int'(mem_req_data.source) != (c - 1) % N) begin
          fails++; $display("FAIL rr_mem_src cyc=%0d got=%b/%0d exp=1/%0d", c, mem_req_valid, mem_req_data.source, (c - 1) % N);
        end
      end
      model_clock();
    end
  endtask

  task automatic test_backpressure();
    int grants;
    do_reset();
    grants = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      req_valid = 4'b0010;
      req_data[1] = mk(1, 100 + c);
      mem_req_ready = 1'b0;
      #1;
      model_expect();
      if (req_ready == 4'b0010) grants++;
      if (c >= 4) begin
        tests++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL bp_full_ready cyc=%0d got=%b exp=0000", c, req_ready); end
      end
      model_clock();
    end
    tests++; if (grants != 4) begin fails++; $display("FAIL bp_grant_count got=%0d exp=4", grants); end
    for (int d = 0; d < 5; d++) begin
      @(negedge clk);
      req_valid = '0;
      mem_req_ready = 1'b1;
      #1;
      model_expect();
      if (d < 4) begin
        tests++;
        if (mem_req_valid !== 1'b1 || mem_req_data !== mk(1, 100 + d)) begin
          fails++; $display("FAIL bp_drain d=%0d got=%b/%h exp=1/%h", d, mem_req_valid, mem_req_data, mk(1, 100 + d));
        end
      end else begin
        tests++; if (mem_req_valid !== 1'b0) begin fails++; $display("FAIL bp_drained got=%b exp=0", mem_req_valid); end
      end
      model_clock();
    end
  endtask

  task automatic test_rsp_order();
    int srcs[3] = '{2, 0, 2};
    logic [N-1:0] exp_v[4] = '{4'b0100, 4'b0001, 4'b0100, 4'b0000};
    int exp_a[4] = '{200, 201, 202, 0};
    do_reset();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      mem_rsp_valid = (c < 3);
      mem_rsp_data  = (c < 3) ? mk(srcs[c], 200 + c) : '0;
      rsp_ready     = (c < 4) ? 4'b0001 : 4'b0101;
      #1;
      model_expect();
      if (c >= 1 && c <= 3) begin
        tests++;
        if (rsp_valid !== 4'b0100 || rsp_data !== mk(2, 200)) begin
          fails++; $display("FAIL rsp_hold cyc=%0d got=%b/%h exp=0100/%h", c, rsp_valid, rsp_data, mk(2, 200));
        end
      end
      if (c >= 4) begin
        tests++;
        if (rsp_valid !== exp_v[c-4] || (exp_v[c-4] != 0 && int'(rsp_data.address) != exp_a[c-4])) begin
          fails++; $display("FAIL rsp_order cyc=%0d got=%b/%0d exp=%b/%0d", c, rsp_valid, rsp_data.address, exp_v[c-4], exp_a[c-4]);
        end
      end
      model_clock();
    end
  endtask

  task automatic test_rsp_drop();
    do_reset();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      mem_rsp_valid = (c < 2);
      mem_rsp_data  = (c == 0) ? mk(9, 300) : mk(1, 301);
      rsp_ready     = 4'b1111;
      #1;
      model_expect();
      if (c == 1 || c == 3) begin
        tests++; if (rsp_valid !== 4'b0000) begin fails++; $display("FAIL drop_invisible cyc=%0d got=%b exp=0000", c, rsp_valid); end
      end
      if (c == 2) begin
        tests++;
        if (rsp_valid !== 4'b0010 || rsp_data !== mk(1, 301)) begin
          fails++; $display("FAIL drop_next cyc=%0d got=%b/%h exp=0010/%h", c, rsp_valid, rsp_data, mk(1, 301));
        end
      end
`ifdef MEMORY_BUS_STATS_EN
      if (c == 3) begin
        tests++; if (stat_rsp_drops !== 32'd1) begin fails++; $display("FAIL drop_stat got=%0d exp=1", stat_rsp_drops); end
      end
`endif
      model_clock();
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      req_valid = 4'b0100;
      req_data[2] = mk(2, 400 + c);
      mem_req_ready = 1'b0;
      #1;
      model_expect();
      model_clock();
    end
    @(negedge clk);
    req_valid = '0;
    reset = 1'b1;
    #1;
    model_expect();
    tests++; if (mem_req_valid !== 1'b1) begin fails++; $display("FAIL mid_queued got=%b exp=1", mem_req_valid); end
    model_clock();
    @(negedge clk);
    reset = 1'b0;
    req_valid = 4'b1111;
    for (int i = 0; i < N; i++) req_data[i] = mk(i, 500 + i);
    #1;
    model_expect();
    tests++; if (mem_req_valid !== 1'b0) begin fails++; $display("FAIL mid_flushed got=%b exp=0", mem_req_valid); end
    tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL mid_ptr got=%b exp=0001", req_ready); end
    model_clock();
  endtask

  task automatic test_random();
    int r;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      req_valid = 4'($urandom);
      for (int i = 0; i < N; i++) begin
        req_data[i] = mk(i, int'($urandom_range(0, 65535)));
        req_data[i].ptype = bus_packet_type_t'(2'($urandom_range(0, 2)));
      end
      mem_req_ready = ($urandom_range(0, 3) != 0);
      mem_rsp_valid = ($urandom_range(0, 2) != 0);
      r = int'($urandom_range(0, 4));
      mem_rsp_data = mk((r == 4) ? 9 : r, int'($urandom_range(0, 65535)));
      mem_rsp_data.ptype = bus_read_response;
      rsp_ready = 4'($urandom);
      #1;
      model_expect();
      tests++; if (req_ready !== e_req_ready) begin fails++; $display("FAIL rnd_req_ready cyc=%0d got=%b exp=%b", c, req_ready, e_req_ready); end
      tests++; if (mem_req_valid !== e_mem_req_valid) begin fails++; $display("FAIL rnd_mem_req_valid cyc=%0d got=%b exp=%b", c, mem_req_valid, e_mem_req_valid); end
      if (e_mem_req_valid) begin
        tests++; if (mem_req_data !== e_mem_req_data) begin fails++; $display("FAIL rnd_mem_req_data cyc=%0d got=%h exp=%h", c, mem_req_data, e_mem_req_data); end
      end
      tests++; if (mem_rsp_ready !== e_mem_rsp_ready) begin fails++; $display("FAIL rnd_mem_rsp_ready cyc=%0d got=%b exp=%b", c, mem_rsp_ready, e_mem_rsp_ready); end
      tests++; if (rsp_valid !== e_rsp_valid) begin fails++; $display("FAIL rnd_rsp_valid cyc=%0d got=%b exp=%b", c, rsp_valid, e_rsp_valid); end
      if (e_rsp_valid != '0) begin
        tests++; if (rsp_data !== e_rsp_data) begin fails++; $display("FAIL rnd_rsp_data cyc=%0d got=%h exp=%h", c, rsp_data, e_rsp_data); end
      end
      model_clock();
    end
`ifdef MEMORY_BUS_STATS_EN
    @(negedge clk);
    idle_inputs();
    tests++;
    if (stat_grants !== st_g[31:0] || stat_req_stalls !== st_s[31:0] || stat_rsp_drops !== st_d[31:0]) begin
      fails++; $display("FAIL rnd_stats got=%0d/%0d/%0d exp=%0d/%0d/%0d", stat_grants, stat_req_stalls, stat_rsp_drops, st_g, st_s, st_d);
    end
`endif
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_round_robin();
    test_backpressure();
    test_rsp_order();
    test_rsp_drop();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/memory_bus_arbiter.md
# memory_bus_arbiter

Parametrised successor to the single-slot memory bus. It connects `NUM_CLIENTS` requesters (fetch, load/store, DMA, …) to one memory port through a round-robin arbiter and a request FIFO. A response FIFO returns read responses to the requester named in each packet's `source` field. It replaces the one-deep, assert-on-collision busy-flag slots with valid/ready back-pressure and buffering in both directions.

## Interface
Parameters:
- `NUM_CLIENTS`, 4: number of requesters; 2..16.
- `REQ_DEPTH`, 4: request FIFO entries; power of two, ≥2.
- `RSP_DEPTH`, 4: response FIFO entries; power of two, ≥2.

Ports (`BusPacket` from the shared package: `type`, `source` of type `BusID`, `address` of type `memory_address_t`, `payload` of type `bus_packet_payload_t`). Clock and reset are one clock and a synchronous, active-high reset:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  NUM_CLIENTS  client i offers `req_data[i]`.
- `req_data`  in  NUM_CLIENTS×BusPacket  request packets.
- `req_ready`  out  NUM_CLIENTS  one-hot or zero; client i's packet is accepted this cycle.
- `mem_req_valid`  out  1  request FIFO head valid.
- `mem_req_data`  out  BusPacket  request FIFO head.
- `mem_req_ready`  in  1  memory consumes the head.
- `mem_rsp_valid`  in  1  memory offers a response.
- `mem_rsp_data`  in  BusPacket  response packet.
- `mem_rsp_ready`  out  1  response FIFO not full.
- `rsp_valid`  out  NUM_CLIENTS  one-hot or zero; the response is for client i.
- `rsp_data`  out  BusPacket  response FIFO head, broadcast to all clients.
- `rsp_ready`  in  NUM_CLIENTS  client i takes the response.

## Operation
- **Reset values:** `req_ready`=0, `mem_req_valid`=0, `mem_rsp_ready`=1 (both FIFOs empty), `rsp_valid`=0, round-robin pointer=0.
- **Arbitration:**
  - If the request FIFO count < `REQ_DEPTH`, grant the first asserted `req_valid` at or after the pointer, searching upward and wrapping modulo `NUM_CLIENTS`.
  - `req_ready` equals the grant vector; it is combinational from `req_valid`, the pointer and the count.
  - On a grant to client g, the pointer becomes (g+1) mod `NUM_CLIENTS`. Without a grant, the pointer holds.
- **Request FIFO:**
  - Push on a grant; pop on `mem_req_valid && mem_req_ready`.
  - Push and pop in the same cycle are allowed; the count is unchanged.
  - When full, `req_ready` is all-zero, even if a pop occurs that cycle. This keeps the ready path free of any dependency on `mem_req_ready`.
  - Packets pass through unmodified. The `source` field is the requester's own responsibility.
- **Response FIFO:**
  - Push on `mem_rsp_valid && mem_rsp_ready`.
  - If the head `source` < `NUM_CLIENTS`, assert `rsp_valid[source]` and pop when `rsp_ready[source]`. `rsp_ready` from other clients is ignored.
  - If the head `source` ≥ `NUM_CLIENTS`, the head is dropped (popped) in the cycle it reaches the head, with no `rsp_valid`.
  - Strict in-order delivery; head-of-line blocking is accepted.
- Write requests produce no response from this block. The memory side decides whether to acknowledge.
- **Mid-operation reset:** both FIFOs empty, in-flight packets are discarded, and the pointer returns to 0 on the next edge.

## Timing
- Request latency: packet accepted at edge t appears on `mem_req_data` after edge t (the following cycle), provided the FIFO ahead of it is empty. Minimum one cycle, no combinational bypass.
- Response latency: same, one cycle from `mem_rsp` acceptance to `rsp_valid`.
- Throughput: one request and one response per cycle sustained.
- Valid/ready rule: a sender holds valid and data stable until ready. This block never deasserts `mem_req_valid` or `rsp_valid` without a pop.
- Count width is $clog2(DEPTH)+1. Read and write pointers wrap modulo DEPTH.

## Configuration
- `MEMORY_BUS_STATS_EN`: when defined, adds the following outputs. All reset to 0, saturate at 2³²−1, and are cleared only by `reset`.
  - `stat_grants`  out  32  total granted requests.
  - `stat_req_stalls`  out  32  cycles with any `req_valid` but no grant.
  - `stat_rsp_drops`  out  32  responses dropped for out-of-range `source`.
- When undefined, these ports and counters are absent. The remaining behaviour is identical.

## Structure
- Shared package (existing bus package): `BusPacket`, `BusID`, `memory_address_t`, `bus_packet_payload_t`, and the packet type enum (`bus_read_data`, `bus_write_data`, `bus_read_response`).
- Sub-module `bus_packet_fifo`, parametrised by `DEPTH`, with push/pop/full/empty and a registered head. It is instantiated twice.
- The round-robin arbiter stays inline in `memory_bus_arbiter`.

## Test plan
- Reset, then idle → `mem_rsp_ready`=1, all other outputs 0, and stats counters 0.
- Clients 0,1,2,3 all valid continuously, `mem_req_ready`=1 → grants in order 0,1,2,3,0…; `mem_req_data.source` follows the same order one cycle later.
- `mem_req_ready`=0, client 1 valid for 6 cycles, `REQ_DEPTH`=4 → exactly 4 grants, then `req_ready`=0. Raising `mem_req_ready` drains packets in order.
- Responses with source 2,0,2 pushed back-to-back, client 2 `rsp_ready`=0 for 3 cycles → `rsp_valid`=4'b0100 held with stable data. Source 0 is not delivered until source 2 is taken.
- Response with source=9 (`NUM_CLIENTS`=4) → never visible on `rsp_valid`; dropped in one cycle; `stat_rsp_drops`=1 with `MEMORY_BUS_STATS_EN`.
- Reset asserted with 3 queued requests → `mem_req_valid`=0 the next cycle, and the next grant goes to client 0.
